// File: rtl/usb_tx.sv
// usb_tx: serialises handshake, status and data packets onto an 8-bit stream.
// usb_txd_o carries the byte belonging to the current state; it reads 8'h00 outside packets.
// CRC engines are LSB-first: CRC5 (x^5+x^2+1, init 5'h1F) and CRC16 (0x8005, init 16'hFFFF).
// The transmitted CRC is the complemented register. The CRC5 byte is {3'b000, crc5}.
module usb_tx (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        fs_i,
   output logic        fd_o,
   input  logic [3:0]  btype_i,
   input  logic [15:0] pkt_num_i,
   input  logic [3:0]  dev_idx_i,
   input  logic [3:0]  data_idx_i,
   input  logic [3:0]  dev_stat_i,
   input  logic [7:0]  stat_val_i,
   input  logic [11:0] data_len_i,
   input  logic [11:0] ram_rxa_init_i,
   output logic [11:0] ram_rxa_o,
   input  logic [7:0]  ram_rxd_i,
   output logic [7:0]  usb_txd_o,
   output logic        busy_o,
   output logic        err_o
);

   typedef enum logic [4:0] {
      S_IDLE, S_WAIT, S_SYNC, S_PID, S_SNUM0, S_SNUM1, S_STAT0, S_STAT1, S_CRC5,
      S_DNUM0, S_DNUM1, S_HEAD0, S_HEAD1, S_PDATA, S_CRC160, S_CRC161, S_EROR, S_DONE
   } state_e;

   // One byte through the reflected CRC5 register, LSB first.
   function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] data);
      logic [4:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ data[i]) c = (c >> 1) ^ 5'h14;
         else                c = c >> 1;
      end
      return c;
   endfunction

   // One byte through the reflected CRC16 register, LSB first.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ data[i]) c = (c >> 1) ^ 16'hA001;
         else                c = c >> 1;
      end
      return c;
   endfunction

   // A request is legal for a known packet kind; data packets also need 1..4093 bytes.
   function automatic logic req_legal(input logic [3:0] bt, input logic [11:0] len);
      logic ok;
      case (bt)
         4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA: ok = 1'b1;
         4'hD, 4'hE:                         ok = (len != 12'd0) && (len <= 12'd4093);
         default:                            ok = 1'b0;
      endcase
      return ok;
   endfunction

   state_e      state_q, state_d;
   logic [3:0]  btype_q, dev_idx_q, data_idx_q, dev_stat_q;
   logic [15:0] pkt_num_q;
   logic [7:0]  stat_val_q;
   logic [11:0] len_q, cnt_q, ram_rxa_q;
   logic [4:0]  crc5_q;
   logic [15:0] crc16_q;
   logic [7:0]  txd_q, txd_d;
   logic        fd_q, busy_q, busy_d, err_q;
   logic        start_s, crc5_en_s, crc16_en_s;
   logic [7:0]  pid_s;
   logic [3:0]  head_s;
   logic [11:0] len_plus_s;

   assign len_plus_s = len_q + 12'd2;

   // Decode PID byte and status header nibble from the latched packet kind.
   always_comb begin
      pid_s  = 8'h00;
      head_s = 4'h0;
      case (btype_q)
         4'h1:    pid_s = 8'h2D;
         4'h2:    pid_s = 8'hA5;
         4'h3:    pid_s = 8'hE1;
         4'h8:    begin pid_s = 8'hD2; head_s = 4'hD; end
         4'h9:    begin pid_s = 8'hD2; head_s = 4'h1; end
         4'hA:    begin pid_s = 8'hD2; head_s = 4'h9; end
         4'hD:    pid_s = 8'h96;
         4'hE:    pid_s = 8'h5A;
         default: pid_s = 8'h00;
      endcase
   end

   // Next-state logic; the byte and CRC enables follow from the state being entered.
   always_comb begin
      state_d    = state_q;
      start_s    = 1'b0;
      txd_d      = 8'h00;
      crc5_en_s  = 1'b0;
      crc16_en_s = 1'b0;
      case (state_q)
         S_IDLE:  state_d = S_WAIT;
         S_WAIT: begin
            if (fs_i && req_legal(btype_i, data_len_i)) begin
               state_d = S_SYNC;
               start_s = 1'b1;
            end else if (fs_i) begin
               state_d = S_EROR;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_SYNC:  state_d = S_PID;
         S_PID: begin
            case (btype_q)
               4'h8, 4'h9, 4'hA: state_d = S_SNUM0;
               4'hD, 4'hE:       state_d = S_DNUM0;
               default:          state_d = S_DONE;
            endcase
         end
         S_SNUM0:  state_d = S_SNUM1;
         S_SNUM1:  state_d = S_STAT0;
         S_STAT0:  state_d = S_STAT1;
         S_STAT1:  state_d = S_CRC5;
         S_CRC5:   state_d = S_DONE;
         S_DNUM0:  state_d = S_DNUM1;
         S_DNUM1:  state_d = S_HEAD0;
         S_HEAD0:  state_d = S_HEAD1;
         S_HEAD1:  state_d = S_PDATA;
         S_PDATA: begin
            if (cnt_q == len_q) state_d = S_CRC160;
            else                state_d = S_PDATA;
         end
         S_CRC160: state_d = S_CRC161;
         S_CRC161: state_d = S_DONE;
         S_EROR:   state_d = S_DONE;
         S_DONE: begin
            if (fs_i) state_d = S_DONE;
            else      state_d = S_WAIT;
         end
         default:  state_d = S_IDLE;
      endcase

      case (state_d)
         S_SYNC:   txd_d = 8'h0F;
         S_PID:    txd_d = pid_s;
         S_SNUM0:  txd_d = pkt_num_q[15:8];
         S_SNUM1:  begin txd_d = pkt_num_q[7:0];         crc5_en_s  = 1'b1; end
         S_STAT0:  begin txd_d = {head_s, dev_idx_q};    crc5_en_s  = 1'b1; end
         S_STAT1:  begin txd_d = stat_val_q;             crc5_en_s  = 1'b1; end
         S_CRC5:   txd_d = {3'b000, ~crc5_q};
         S_DNUM0:  txd_d = {4'h0, len_plus_s[11:8]};
         S_DNUM1:  begin txd_d = len_plus_s[7:0];        crc16_en_s = 1'b1; end
         S_HEAD0:  begin txd_d = {4'h3, dev_idx_q};      crc16_en_s = 1'b1; end
         S_HEAD1:  begin txd_d = {data_idx_q, dev_stat_q}; crc16_en_s = 1'b1; end
         S_PDATA:  begin txd_d = ram_rxd_i;              crc16_en_s = 1'b1; end
         S_CRC160: txd_d = ~crc16_q[15:8];
         S_CRC161: txd_d = ~crc16_q[7:0];
         default:  txd_d = 8'h00;
      endcase
   end

   assign busy_d = !(state_d inside {S_IDLE, S_WAIT, S_EROR, S_DONE});

   // State register and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         txd_q   <= 8'h00;
         busy_q  <= 1'b0;
         fd_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         fd_q    <= (state_d == S_DONE);
         if (start_s)                err_q <= 1'b0;
         else if (state_d == S_EROR) err_q <= 1'b1;
         else                        err_q <= err_q;
      end
   end

   // Request fields are captured once at start so later input changes cannot corrupt a packet.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         btype_q    <= 4'h0;
         pkt_num_q  <= 16'h0000;
         dev_idx_q  <= 4'h0;
         data_idx_q <= 4'h0;
         dev_stat_q <= 4'h0;
         stat_val_q <= 8'h00;
         len_q      <= 12'h000;
      end else if (start_s) begin
         btype_q    <= btype_i;
         pkt_num_q  <= pkt_num_i;
         dev_idx_q  <= dev_idx_i;
         data_idx_q <= data_idx_i;
         dev_stat_q <= dev_stat_i;
         stat_val_q <= stat_val_i;
         len_q      <= data_len_i;
      end else begin
         btype_q    <= btype_q;
      end
   end

   // Payload address runs one cycle ahead of the byte stream to cover the RAM read latency.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ram_rxa_q <= 12'h000;
         cnt_q     <= 12'h000;
      end else if (start_s) begin
         ram_rxa_q <= ram_rxa_init_i;
         cnt_q     <= 12'h000;
      end else begin
         if (state_d == S_HEAD1 || state_d == S_PDATA) ram_rxa_q <= ram_rxa_q + 12'd1;
         else                                          ram_rxa_q <= ram_rxa_q;
         if (state_d == S_PDATA) cnt_q <= cnt_q + 12'd1;
         else                    cnt_q <= cnt_q;
      end
   end

   // CRC registers accumulate only the bytes they protect.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         crc5_q  <= 5'h00;
         crc16_q <= 16'h0000;
      end else if (start_s) begin
         crc5_q  <= 5'h1F;
         crc16_q <= 16'hFFFF;
      end else begin
         if (crc5_en_s)  crc5_q  <= crc5_byte(crc5_q, txd_d);
         else            crc5_q  <= crc5_q;
         if (crc16_en_s) crc16_q <= crc16_byte(crc16_q, txd_d);
         else            crc16_q <= crc16_q;
      end
   end

   assign usb_txd_o = txd_q;
   assign busy_o    = busy_q;
   assign fd_o      = fd_q;
   assign err_o     = err_q;
   assign ram_rxa_o = ram_rxa_q;

endmodule

// File: tb/tb_usb_tx.sv
// tb_usb_tx: directed and randomised byte-stream checks for usb_tx with a 1-cycle-latency RAM.
module tb_usb_tx;

   logic        clk, rst_n, fs, fd, busy, err;
   logic [3:0]  btype, dev_idx, data_idx, dev_stat;
   logic [15:0] pkt_num;
   logic [7:0]  stat_val, ram_rxd, usb_txd;
   logic [11:0] data_len, ram_rxa_init, ram_rxa;

   logic [7:0]  mem [0:4095];
   logic [7:0]  cap_txd  [0:63];
   logic        cap_fd   [0:63];
   logic        cap_busy [0:63];
   logic        cap_err  [0:63];
   logic [7:0]  exp_q [$];
   int          checks, errors;

   usb_tx dut (
      .clk_i(clk), .rst_ni(rst_n), .fs_i(fs), .fd_o(fd), .btype_i(btype),
      .pkt_num_i(pkt_num), .dev_idx_i(dev_idx), .data_idx_i(data_idx),
      .dev_stat_i(dev_stat), .stat_val_i(stat_val), .data_len_i(data_len),
      .ram_rxa_init_i(ram_rxa_init), .ram_rxa_o(ram_rxa), .ram_rxd_i(ram_rxd),
      .usb_txd_o(usb_txd), .busy_o(busy), .err_o(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Payload RAM with one cycle of read latency.
   always @(posedge clk) ram_rxd <= mem[ram_rxa];

   // Reference CRCs in non-reflected form on a bit-reversed register.
   function automatic logic [4:0] m_crc5_step(input logic [4:0] r, input logic [7:0] d);
      logic [4:0] x;
      logic       fb;
      x = r;
      for (int i = 0; i < 8; i++) begin
         fb = x[4] ^ d[i];
         x  = {x[3:0], 1'b0};
         if (fb) x = x ^ 5'h05;
      end
      return x;
   endfunction

   function automatic logic [4:0] m_crc5_out(input logic [4:0] r);
      logic [4:0] o;
      for (int i = 0; i < 5; i++) o[i] = ~r[4-i];
      return o;
   endfunction

   function automatic logic [15:0] m_crc16_step(input logic [15:0] r, input logic [7:0] d);
      logic [15:0] x;
      logic        fb;
      x = r;
      for (int i = 0; i < 8; i++) begin
         fb = x[15] ^ d[i];
         x  = {x[14:0], 1'b0};
         if (fb) x = x ^ 16'h8005;
      end
      return x;
   endfunction

   function automatic logic [15:0] m_crc16_out(input logic [15:0] r);
      logic [15:0] o;
      for (int i = 0; i < 16; i++) o[i] = ~r[15-i];
      return o;
   endfunction

   // Expected packet bytes for the request currently on the inputs.
   task automatic build_expected();
      logic [4:0]  r5;
      logic [15:0] r16, c16;
      logic [11:0] l, a;
      logic [3:0]  hd;
      logic [7:0]  b;
      exp_q = {};
      exp_q.push_back(8'h0F);
      case (btype)
         4'h1: exp_q.push_back(8'h2D);
         4'h2: exp_q.push_back(8'hA5);
         4'h3: exp_q.push_back(8'hE1);
         4'h8, 4'h9, 4'hA: begin
            hd = (btype == 4'h8) ? 4'hD : (btype == 4'h9) ? 4'h1 : 4'h9;
            exp_q.push_back(8'hD2);
            exp_q.push_back(pkt_num[15:8]);
            exp_q.push_back(pkt_num[7:0]);
            exp_q.push_back({hd, dev_idx});
            exp_q.push_back(stat_val);
            r5 = m_crc5_step(5'h1F, pkt_num[7:0]);
            r5 = m_crc5_step(r5, {hd, dev_idx});
            r5 = m_crc5_step(r5, stat_val);
            exp_q.push_back({3'b000, m_crc5_out(r5)});
         end
         default: begin
            exp_q.push_back((btype == 4'hD) ? 8'h96 : 8'h5A);
            l = data_len + 12'd2;
            exp_q.push_back({4'h0, l[11:8]});
            exp_q.push_back(l[7:0]);
            exp_q.push_back({4'h3, dev_idx});
            exp_q.push_back({data_idx, dev_stat});
            r16 = m_crc16_step(16'hFFFF, l[7:0]);
            r16 = m_crc16_step(r16, {4'h3, dev_idx});
            r16 = m_crc16_step(r16, {data_idx, dev_stat});
            a = ram_rxa_init;
            for (int k = 0; k < int'(data_len); k++) begin
               b = mem[a];
               exp_q.push_back(b);
               r16 = m_crc16_step(r16, b);
               a = a + 12'd1;
            end
            c16 = m_crc16_out(r16);
            exp_q.push_back(c16[15:8]);
            exp_q.push_back(c16[7:0]);
         end
      endcase
   endtask

   // Raise fs on a falling edge; the DUT must be sitting in WAIT.
   task automatic start_pkt();
      @(negedge clk);
      fs = 1'b1;
   endtask

   // Record n cycles of outputs. mode 0: drop fs; 1: hold fs; 2: toggle fs while busy;
   // 3: drop fs and scramble all request inputs after the first byte.
   task automatic capture(input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cap_txd[i]  = usb_txd;
         cap_fd[i]   = fd;
         cap_busy[i] = busy;
         cap_err[i]  = err;
         case (mode)
            0: fs = 1'b0;
            1: fs = 1'b1;
            2: fs = busy ? 1'($urandom_range(0, 1)) : 1'b0;
            default: begin
               fs = 1'b0;
               if (i == 0) begin
                  btype = 4'h3; pkt_num = 16'($urandom); dev_idx = 4'($urandom);
                  data_idx = 4'($urandom); dev_stat = 4'($urandom); stat_val = 8'($urandom);
                  data_len = 12'd40; ram_rxa_init = 12'($urandom);
               end
            end
         endcase
      end
   endtask

   task automatic test_reset();
      fs = 1'b0; btype = 4'h0; pkt_num = 16'h0000; dev_idx = 4'h0; data_idx = 4'h0;
      dev_stat = 4'h0; stat_val = 8'h00; data_len = 12'h000; ram_rxa_init = 12'h000;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (usb_txd !== 8'h00) begin errors++; $display("FAIL reset_txd got %h exp 00", usb_txd); end
      checks++; if (fd !== 1'b0) begin errors++; $display("FAIL reset_fd got %b exp 0", fd); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
      checks++; if (ram_rxa !== 12'h000) begin errors++; $display("FAIL reset_rxa got %h exp 000", ram_rxa); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ack();
      logic [7:0] et [5];
      logic       ef [5];
      logic       eb [5];
      et = '{8'h0F, 8'h2D, 8'h00, 8'h00, 8'h00};
      ef = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      eb = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      btype = 4'h1;
      start_pkt();
      capture(5, 0);
      for (int i = 0; i < 5; i++) begin
         checks++; if (cap_txd[i] !== et[i]) begin errors++; $display("FAIL ack_txd[%0d] got %h exp %h", i, cap_txd[i], et[i]); end
         checks++; if (cap_fd[i] !== ef[i]) begin errors++; $display("FAIL ack_fd[%0d] got %b exp %b", i, cap_fd[i], ef[i]); end
         checks++; if (cap_busy[i] !== eb[i]) begin errors++; $display("FAIL ack_busy[%0d] got %b exp %b", i, cap_busy[i], eb[i]); end
      end
   endtask

   task automatic test_status();
      logic [7:0] et [9];
      logic [4:0] r5;
      r5 = m_crc5_step(5'h1F, 8'h02);
      r5 = m_crc5_step(r5, 8'h13);
      r5 = m_crc5_step(r5, 8'h5A);
      et = '{8'h0F, 8'hD2, 8'h01, 8'h02, 8'h13, 8'h5A, {3'b000, m_crc5_out(r5)}, 8'h00, 8'h00};
      btype = 4'h9; pkt_num = 16'h0102; dev_idx = 4'h3; stat_val = 8'h5A;
      start_pkt();
      capture(9, 0);
      for (int i = 0; i < 9; i++) begin
         checks++; if (cap_txd[i] !== et[i]) begin errors++; $display("FAIL status_txd[%0d] got %h exp %h", i, cap_txd[i], et[i]); end
      end
      checks++; if (cap_busy[6] !== 1'b1 || cap_busy[7] !== 1'b0) begin errors++; $display("FAIL status_busy got %b%b exp 10", cap_busy[6], cap_busy[7]); end
      checks++; if (cap_fd[7] !== 1'b1 || cap_fd[8] !== 1'b0) begin errors++; $display("FAIL status_fd got %b%b exp 10", cap_fd[7], cap_fd[8]); end
   endtask

   task automatic test_data_wrap();
      logic [7:0]  et [14];
      logic [15:0] r16, c16;
      mem[12'hFFE] = 8'h11; mem[12'hFFF] = 8'h22; mem[12'h000] = 8'h33; mem[12'h001] = 8'h44;
      r16 = 16'hFFFF;
      r16 = m_crc16_step(r16, 8'h06); r16 = m_crc16_step(r16, 8'h35); r16 = m_crc16_step(r16, 8'h72);
      r16 = m_crc16_step(r16, 8'h11); r16 = m_crc16_step(r16, 8'h22);
      r16 = m_crc16_step(r16, 8'h33); r16 = m_crc16_step(r16, 8'h44);
      c16 = m_crc16_out(r16);
      et = '{8'h0F, 8'h96, 8'h00, 8'h06, 8'h35, 8'h72, 8'h11, 8'h22, 8'h33, 8'h44,
             c16[15:8], c16[7:0], 8'h00, 8'h00};
      btype = 4'hD; data_len = 12'd4; ram_rxa_init = 12'hFFE;
      dev_idx = 4'h5; data_idx = 4'h7; dev_stat = 4'h2;
      start_pkt();
      capture(14, 3);
      for (int i = 0; i < 14; i++) begin
         checks++; if (cap_txd[i] !== et[i]) begin errors++; $display("FAIL data_txd[%0d] got %h exp %h", i, cap_txd[i], et[i]); end
      end
      checks++; if (cap_fd[12] !== 1'b1) begin errors++; $display("FAIL data_fd got %b exp 1", cap_fd[12]); end
   endtask

   task automatic test_data_len1();
      logic [7:0]  et [11];
      logic [15:0] r16, c16;
      mem[12'h010] = 8'hA7;
      r16 = m_crc16_step(16'hFFFF, 8'h03); r16 = m_crc16_step(r16, 8'h30);
      r16 = m_crc16_step(r16, 8'hFF); r16 = m_crc16_step(r16, 8'hA7);
      c16 = m_crc16_out(r16);
      et = '{8'h0F, 8'h5A, 8'h00, 8'h03, 8'h30, 8'hFF, 8'hA7, c16[15:8], c16[7:0], 8'h00, 8'h00};
      btype = 4'hE; data_len = 12'd1; ram_rxa_init = 12'h010;
      dev_idx = 4'h0; data_idx = 4'hF; dev_stat = 4'hF;
      start_pkt();
      capture(11, 0);
      for (int i = 0; i < 11; i++) begin
         checks++; if (cap_txd[i] !== et[i]) begin errors++; $display("FAIL len1_txd[%0d] got %h exp %h", i, cap_txd[i], et[i]); end
      end
   endtask

   task automatic test_illegal();
      logic [3:0]  bt [4];
      logic [11:0] ln [4];
      bt = '{4'h7, 4'hD, 4'hE, 4'hF};
      ln = '{12'd4, 12'd0, 12'd4094, 12'd4};
      for (int c = 0; c < 4; c++) begin
         btype = bt[c]; data_len = ln[c];
         start_pkt();
         capture(3, 0);
         for (int i = 0; i < 3; i++) begin
            checks++; if (cap_txd[i] !== 8'h00 || cap_busy[i] !== 1'b0) begin errors++; $display("FAIL illegal%0d_quiet[%0d] got %h/%b exp 00/0", c, i, cap_txd[i], cap_busy[i]); end
         end
         checks++; if (cap_err[0] !== 1'b1) begin errors++; $display("FAIL illegal%0d_err got %b exp 1", c, cap_err[0]); end
         checks++; if (cap_fd[0] !== 1'b0 || cap_fd[1] !== 1'b1 || cap_fd[2] !== 1'b0) begin errors++; $display("FAIL illegal%0d_fd got %b%b%b exp 010", c, cap_fd[0], cap_fd[1], cap_fd[2]); end
      end
   endtask

   task automatic test_back_to_back();
      // NAK with fs held high: one packet only, DONE held, err cleared by the accepted start.
      btype = 4'h2;
      start_pkt();
      capture(8, 1);
      checks++; if (cap_err[0] !== 1'b0) begin errors++; $display("FAIL b2b_err_clear got %b exp 0", cap_err[0]); end
      checks++; if (cap_txd[0] !== 8'h0F || cap_txd[1] !== 8'hA5) begin errors++; $display("FAIL b2b_nak got %h %h exp 0f a5", cap_txd[0], cap_txd[1]); end
      for (int i = 2; i < 8; i++) begin
         checks++; if (cap_txd[i] !== 8'h00 || cap_fd[i] !== 1'b1) begin errors++; $display("FAIL b2b_hold[%0d] got %h/%b exp 00/1", i, cap_txd[i], cap_fd[i]); end
      end
      fs = 1'b0;
      @(negedge clk);
      checks++; if (fd !== 1'b0) begin errors++; $display("FAIL b2b_fd_fall got %b exp 0", fd); end
      btype = 4'h3;
      start_pkt();
      capture(3, 0);
      checks++; if (cap_txd[0] !== 8'h0F || cap_txd[1] !== 8'hE1 || cap_txd[2] !== 8'h00) begin errors++; $display("FAIL b2b_stl got %h %h %h exp 0f e1 00", cap_txd[0], cap_txd[1], cap_txd[2]); end
   endtask

   task automatic test_reset_mid();
      btype = 4'hD; data_len = 12'd8; ram_rxa_init = 12'h100;
      dev_idx = 4'h1; data_idx = 4'h2; dev_stat = 4'h3;
      start_pkt();
      capture(8, 1);
      checks++; if (cap_txd[6] !== mem[12'h100] || cap_txd[7] !== mem[12'h101]) begin errors++; $display("FAIL mid_payload got %h %h exp %h %h", cap_txd[6], cap_txd[7], mem[12'h100], mem[12'h101]); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (usb_txd !== 8'h00 || busy !== 1'b0 || fd !== 1'b0) begin errors++; $display("FAIL mid_reset got %h/%b/%b exp 00/0/0", usb_txd, busy, fd); end
      fs = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      btype = 4'h1;
      start_pkt();
      capture(3, 0);
      checks++; if (cap_txd[0] !== 8'h0F || cap_txd[1] !== 8'h2D || cap_txd[2] !== 8'h00) begin errors++; $display("FAIL mid_ack got %h %h %h exp 0f 2d 00", cap_txd[0], cap_txd[1], cap_txd[2]); end
   endtask

   task automatic test_random();
      logic [3:0] kinds [8];
      int         n;
      kinds = '{4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA, 4'hD, 4'hE};
      for (int t = 0; t < 8; t++) begin
         btype = kinds[$urandom_range(0, 7)];
         pkt_num = 16'($urandom); dev_idx = 4'($urandom); data_idx = 4'($urandom);
         dev_stat = 4'($urandom); stat_val = 8'($urandom);
         data_len = 12'($urandom_range(1, 20)); ram_rxa_init = 12'($urandom);
         build_expected();
         n = exp_q.size();
         start_pkt();
         capture(n + 2, 2);
         for (int i = 0; i < n; i++) begin
            checks++; if (cap_txd[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_txd[%0d] got %h exp %h", t, i, cap_txd[i], exp_q[i]); end
         end
         checks++; if (cap_txd[n] !== 8'h00 || cap_txd[n+1] !== 8'h00 || cap_fd[n] !== 1'b1 || cap_fd[n+1] !== 1'b0) begin errors++; $display("FAIL rand%0d_tail got %h %h fd %b%b exp 00 00 fd 10", t, cap_txd[n], cap_txd[n+1], cap_fd[n], cap_fd[n+1]); end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      test_reset();
      test_ack();
      test_status();
      test_data_wrap();
      test_data_len1();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
